uart_rx: RTL
============

# uart_rx

Serial receiver for the host link: it oversamples the asynchronous RX pin, frames 8N1 characters and emits each received byte as a one-cycle strobe. It sits directly upstream of the Intel-HEX loader and drives its byte input (data plus strobe) with no buffering in between. The loader consumes every strobe in the cycle it is asserted, so there is no back-pressure.

## Interface
- `CLKS_PER_BAUD`, default 434 (50 MHz / 115200): clock cycles per bit. Legal range is 4..65535; a value outside that range is an elaboration error.
- `i_clk` in 1: system clock. This is the only clock.
- `i_reset` in 1: reset, synchronous, active-high.
- `i_uart_rx` in 1: RX pin, asynchronous to `i_clk`. Idle level is 1.
- `o_rx_data` out 8: last good byte, LSB received first. Holds its value until the next good byte.
- `o_rx_stb` out 1: one-cycle pulse; `o_rx_data` is valid in the same cycle.
- `o_frame_err` out 1: one-cycle pulse when the stop bit is sampled as 0.

## Operation
- **Input synchroniser.** Two flops, both reset to 1. In this section, `rx` means the synchroniser output.
- **Counter.** `cnt` is 16 bits and counts down. A sample is taken in the cycle where `cnt == 0`. `bit_idx` is 3 bits.
- **WAIT_IDLE** (reset state). Leave for IDLE after the first cycle with `rx == 1`. This prevents a reset taken mid-frame, or a held break, from being decoded as a start bit.
- **IDLE.** When `rx == 0`: load `cnt = CLKS_PER_BAUD/2 - 1` (integer floor) and go to START.
- **START.** At the sample:
  - `rx == 1`: treat as a glitch and return to IDLE. No output pulse.
  - `rx == 0`: load `cnt = CLKS_PER_BAUD - 1`, set `bit_idx = 0`, go to DATA.
- **DATA.** At each sample:
  - Shift right with the new bit entering `shreg[7]`, and reload `cnt`.
  - When `bit_idx == 7`, go to STOP; otherwise increment `bit_idx`.
- **STOP.** At the sample:
  - `rx == 1`: `o_rx_data <= shreg`, pulse `o_rx_stb`, go to IDLE.
  - `rx == 0`: pulse `o_frame_err`, leave `o_rx_data` unchanged, go to WAIT_IDLE.
- **Exclusivity.** `o_rx_stb` and `o_frame_err` are never high in the same cycle.
- **No parity.** Parity is not supported.
- **Outside the sample cycle.** `rx` is ignored by START, DATA and STOP except in the sample cycle.

## Timing
- **Reset values.**
  - Outputs: `o_rx_data = 8'h00`, `o_rx_stb = 0`, `o_frame_err = 0`.
  - Internal: state WAIT_IDLE, `cnt = 0`, `bit_idx = 0`, `shreg = 0`, sync flops = 1.
- **Reset priority.** `i_reset` has priority over every transition and aborts any frame in progress. No strobe or error pulse is generated for the aborted frame.
- **Sample points.** Let t0 be the first IDLE cycle with `rx == 0`; pin-to-`rx` latency is 2 cycles.
  - Start sample: t0 + floor(C/2).
  - Data bit k sample: t0 + floor(C/2) + (k+1)·C.
  - Stop sample: t0 + floor(C/2) + 9·C.
- **Output registration.** `o_rx_stb` and `o_frame_err` are registered, so they are high in the cycle after the stop sample.
- **Back-to-back frames.** The next start bit is accepted from the cycle after the stop sample. Back-to-back frames need no idle gap.
- **Clock mismatch.** Total bit-clock mismatch of ±2% between transmitter and receiver must be tolerated.

## Structure
- **Shared package `uart_pkg`.**
  - State enum: WAIT_IDLE, IDLE, START, DATA, STOP.
  - `uart_byte_t` = logic [7:0].
  - The same package will later be used by `uart_tx`.
- **Sub-module `sync_2ff`.** Parameter `RESET_VAL` (set to 1 here), synchronous reset. It is reused for other asynchronous pins.
- **Size.** The FSM, counter and shifter live in `uart_rx`, about 150 lines.

## Test plan
All scenarios run with `CLKS_PER_BAUD = 16`.
- **Single byte.** Drive 0x3A (':') on the pin → exactly one `o_rx_stb`, `o_rx_data = 8'h3A`, strobe at start-sample + 9·16 + 1 cycles; `o_frame_err` stays 0.
- **Back-to-back stream.** Drive ":10" + "00" with no gaps → strobes carrying 0x3A, 0x31, 0x30, 0x30, 0x30 in order; each strobe is 1 cycle wide.
- **Start glitch.** A 0 pulse of 5 cycles on an idle line → no strobe and no error; then byte 0x55 → 0x55 received.
- **Framing error.** Byte 0xA5 with stop bit = 0, line held low for 40 cycles and then released → one `o_frame_err` pulse, no strobe, `o_rx_data` keeps its previous value; the next byte 0x4B is received correctly.
- **Reset mid-frame.** Assert `i_reset` for 1 cycle during bit 3 of 0xFF → no strobe for that frame; the receiver resynchronises and the following 0x0D arrives as 0x0D.
- **Baud error.** Bits stretched to 16.3 and to 15.7 cycles (±2%) → 0x00 and 0xFF are both received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, byte type and bit-timing helpers.
// Intended for both the receiver and the future transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } uart_state_e;

  typedef logic [7:0] uart_byte_t;

  localparam int unsigned UART_CNT_W      = 16;
  localparam int unsigned UART_CLKS_MIN   = 4;
  localparam int unsigned UART_CLKS_MAX   = 65535;
  localparam logic [2:0]  UART_LAST_BIT   = 3'd7;

  // Reload value that lands the first sample in the middle of the start bit.
  function automatic logic [UART_CNT_W-1:0] uart_half_bit_m1(input int unsigned clks);
    return UART_CNT_W'((clks / 32'd2) - 32'd1);
  endfunction

  // Reload value for a full bit period between consecutive samples.
  function automatic logic [UART_CNT_W-1:0] uart_full_bit_m1(input int unsigned clks);
    return UART_CNT_W'(clks - 32'd1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input pin.
// RESET_VAL is the level both stages take in reset (the pin's idle level).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // Next-state: each stage copies the stage before it.
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Synchroniser flops with synchronous reset to the idle level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the RX pin, centre-samples each bit with a
// down-counter and emits each good byte as a one-cycle strobe. A stop bit
// sampled low raises a one-cycle framing-error pulse instead.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = 434
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_stb,
  output logic       o_frame_err
);

  generate
    if ((CLKS_PER_BAUD < int'(UART_CLKS_MIN)) || (CLKS_PER_BAUD > int'(UART_CLKS_MAX))) begin : g_bad_clks_per_baud
      $error("uart_rx: CLKS_PER_BAUD must lie in 4..65535");
    end
  endgenerate

  localparam logic [UART_CNT_W-1:0] HALF_BIT_M1 = uart_half_bit_m1(CLKS_PER_BAUD);
  localparam logic [UART_CNT_W-1:0] FULL_BIT_M1 = uart_full_bit_m1(CLKS_PER_BAUD);

  logic rx;
  logic sample;

  uart_state_e           state_q,     state_d;
  logic [UART_CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]            bit_idx_q,   bit_idx_d;
  uart_byte_t            shreg_q,     shreg_d;
  uart_byte_t            rx_data_q,   rx_data_d;
  logic                  rx_stb_q,    rx_stb_d;
  logic                  frame_err_q, frame_err_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_uart_rx),
    .o_q     (rx)
  );

  // The line is only looked at while framing when the counter expires.
  assign sample = (cnt_q == {UART_CNT_W{1'b0}});

  // Next-state, counter, shifter and output-pulse logic of the framer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_stb_d    = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      // Hold off until the line has been seen idle, so a reset in the middle
      // of a frame or a held break is never taken as a start bit.
      WAIT_IDLE: begin
        if (rx) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end

      IDLE: begin
        if (!rx) begin
          cnt_d   = HALF_BIT_M1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      // Mid start bit: a high line here means the falling edge was a glitch.
      START: begin
        if (sample) begin
          if (rx) begin
            state_d = IDLE;
          end else begin
            cnt_d     = FULL_BIT_M1;
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      // LSB arrives first, so shift right and insert at the top.
      DATA: begin
        if (sample) begin
          shreg_d = {rx, shreg_q[7:1]};
          cnt_d   = FULL_BIT_M1;
          if (bit_idx_q == UART_LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      // Returning to IDLE straight after the stop sample lets the next start
      // bit follow with no idle gap.
      STOP: begin
        if (sample) begin
          if (rx) begin
            rx_data_d = shreg_q;
            rx_stb_d  = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      default: begin
        state_d = WAIT_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any frame silently.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= WAIT_IDLE;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_stb_q    <= rx_stb_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_rx_data   = rx_data_q;
  assign o_rx_stb    = rx_stb_q;
  assign o_frame_err = frame_err_q;

endmodule
